// File: rtl/mips_ctrl_pkg.sv
// Shared types for the MIPS multi-cycle controller.
// State codes and memory-address mux selects.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_MULDIV = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

endpackage

// File: rtl/muldiv_countdown.sv
// Loadable down-counter timing the fixed multiply/divide latency.
// Loads MULDIV_CYCLES-1 so the zero flag marks the last wait cycle.
module muldiv_countdown #(
    parameter int unsigned MULDIV_CYCLES = 33
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam int W = $clog2(MULDIV_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(MULDIV_CYCLES - 1);

    logic [W-1:0] count_q;

    // Load on entry, then count down and rest at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= LOAD_VAL;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mips_cycle_controller.sv
// Multi-cycle sequencer: fetch, execute, memory and mult/div wait.
// Strobes are decoded combinationally from state and inputs.
module mips_cycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       waitrequest,
    input  logic       data_read,
    input  logic       data_write,
    input  logic       multdiv,
    input  logic       reg_write_enable,
    input  logic       pc_next_zero,
    output logic       read,
    output logic       write,
    output logic       addr_sel,
    output logic       ir_wren,
    output logic       pc_wren,
    output logic       reg_wren,
    output logic       hilo_wren,
    output logic       active,
    output logic [2:0] state
);

    state_t state_q, state_d;
    state_t commit_next;
    logic   active_q, active_d;
    logic   cnt_load, cnt_en, cnt_zero;

    muldiv_countdown #(
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load_i(cnt_load),
        .en_i  (cnt_en),
        .zero_o(cnt_zero)
    );

    // Next-state and strobe decode; one commit per instruction.
    always_comb begin
        read        = 1'b0;
        write       = 1'b0;
        addr_sel    = ADDR_PC;
        ir_wren     = 1'b0;
        pc_wren     = 1'b0;
        reg_wren    = 1'b0;
        hilo_wren   = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        state_d     = state_q;
        commit_next = pc_next_zero ? S_HALT : S_FETCH;
        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                read = 1'b1;
                if (!waitrequest) begin
                    ir_wren = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (data_read || data_write) begin
                    state_d = S_MEM;
                end else if (multdiv) begin
                    cnt_load = 1'b1;
                    state_d  = S_MULDIV;
                end else begin
                    pc_wren  = 1'b1;
                    reg_wren = reg_write_enable;
                    state_d  = commit_next;
                end
            end
            S_MEM: begin
                addr_sel = ADDR_ALU;
                write    = data_write;
                read     = data_read & ~data_write;
                if (!waitrequest) begin
                    pc_wren  = 1'b1;
                    reg_wren = reg_write_enable;
                    state_d  = commit_next;
                end
            end
            S_MULDIV: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    hilo_wren = 1'b1;
                    pc_wren   = 1'b1;
                    state_d   = commit_next;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        active_d = (state_d == S_FETCH) || (state_d == S_EXEC) ||
                   (state_d == S_MEM) || (state_d == S_MULDIV);
    end

    // State and run flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RESET;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    assign state  = state_q;
    assign active = active_q;

endmodule

// File: tb/tb_mips_cycle_controller.sv
// Self-checking bench for mips_cycle_controller.
// Expected traces are built per instruction from latency rules.
module tb_mips_cycle_controller;

    localparam int MD = 33;

    typedef struct packed {
        logic rd;
        logic wr;
        logic as;
        logic ir;
        logic pc;
        logic rg;
        logic hl;
    } strb_t;

    // kind: 0 ALU, 1 load, 2 store, 3 load+store, 4 mult/div
    typedef struct {
        int   kind;
        int   fw;
        int   mw;
        logic rwe;
        logic pcz;
        int   exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic waitrequest = 1'b0;
    logic data_read = 1'b0;
    logic data_write = 1'b0;
    logic multdiv = 1'b0;
    logic reg_write_enable = 1'b0;
    logic pc_next_zero = 1'b0;
    logic read, write, addr_sel, ir_wren, pc_wren;
    logic reg_wren, hilo_wren, active;
    logic [2:0] state;

    int passes = 0;
    int total = 0;
    int cyc_n = 0;
    int first_pc = -1;

    mips_cycle_controller #(
        .MULDIV_CYCLES(MD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .waitrequest     (waitrequest),
        .data_read       (data_read),
        .data_write      (data_write),
        .multdiv         (multdiv),
        .reg_write_enable(reg_write_enable),
        .pc_next_zero    (pc_next_zero),
        .read            (read),
        .write           (write),
        .addr_sel        (addr_sel),
        .ir_wren         (ir_wren),
        .pc_wren         (pc_wren),
        .reg_wren        (reg_wren),
        .hilo_wren       (hilo_wren),
        .active          (active),
        .state           (state)
    );

    always #5 clk = ~clk;

    function automatic strb_t mk(input logic rd, input logic wr,
                                 input logic as, input logic ir,
                                 input logic pc, input logic rg,
                                 input logic hl);
        strb_t s;
        s = {rd, wr, as, ir, pc, rg, hl};
        return s;
    endfunction

    task automatic check(input logic [2:0] est, input strb_t es,
                         input logic eact, input string nm);
        strb_t got;
        got = {read, write, addr_sel, ir_wren, pc_wren, reg_wren, hilo_wren};
        total++;
        if (state === est && got === es && active === eact) begin
            passes++;
        end else begin
            $display("FAIL %s: got state=%0d strb=%b act=%b, want state=%0d strb=%b act=%b",
                     nm, state, got, active, est, es, eact);
        end
    endtask

    // Called just after a negedge: drive, settle, compare, advance.
    task automatic cyc(input logic wrq, input logic [2:0] est,
                       input strb_t es, input logic eact, input string nm);
        waitrequest = wrq;
        #1;
        cyc_n++;
        if (pc_wren === 1'b1 && first_pc < 0) first_pc = cyc_n;
        check(est, es, eact, nm);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc(1'($urandom), 3'd0, '0, 1'b0, "reset");
        end
        reset = 1'b0;
        cyc(1'b0, 3'd0, '0, 1'b0, "post_reset");
    endtask

    task automatic run_instr(input vec_t v, input string nm);
        logic dr, dw, md;
        dr = (v.kind == 1) || (v.kind == 3);
        dw = (v.kind == 2) || (v.kind == 3);
        md = (v.kind == 4);
        data_read = dr;
        data_write = dw;
        multdiv = md;
        reg_write_enable = v.rwe;
        pc_next_zero = v.pcz;
        cyc_n = 0;
        first_pc = -1;
        for (int i = 0; i < v.fw; i++)
            cyc(1'b1, 3'd1, mk(1, 0, 0, 0, 0, 0, 0), 1'b1, {nm, "_fwait"});
        cyc(1'b0, 3'd1, mk(1, 0, 0, 1, 0, 0, 0), 1'b1, {nm, "_fetch"});
        if (v.kind == 0) begin
            cyc(1'($urandom), 3'd2, mk(0, 0, 0, 0, 1, v.rwe, 0), 1'b1,
                {nm, "_exec"});
        end else if (v.kind == 4) begin
            cyc(1'($urandom), 3'd2, '0, 1'b1, {nm, "_exec"});
            for (int i = 0; i < MD; i++) begin
                logic last;
                last = (i == MD - 1);
                cyc(1'($urandom), 3'd4, mk(0, 0, 0, 0, last, 0, last), 1'b1,
                    {nm, "_muldiv"});
            end
        end else begin
            cyc(1'($urandom), 3'd2, '0, 1'b1, {nm, "_exec"});
            for (int i = 0; i < v.mw; i++)
                cyc(1'b1, 3'd3, mk(dr & ~dw, dw, 1, 0, 0, 0, 0), 1'b1,
                    {nm, "_mwait"});
            cyc(1'b0, 3'd3, mk(dr & ~dw, dw, 1, 0, 1, v.rwe, 0), 1'b1,
                {nm, "_mem"});
        end
        total++;
        if (first_pc == v.exp_lat) begin
            passes++;
        end else begin
            $display("FAIL %s_latency: got %0d cycles, want %0d",
                     nm, first_pc, v.exp_lat);
        end
    endtask

    function automatic int lat_of(input int kind, input int fw, input int mw);
        if (kind == 0) return 2 + fw;
        if (kind == 4) return 2 + MD + fw;
        return 3 + fw + mw;
    endfunction

    vec_t tbl[6];
    vec_t rv;

    initial begin
        tbl[0] = '{kind: 0, fw: 0, mw: 0, rwe: 1'b1, pcz: 1'b0, exp_lat: 2};
        tbl[1] = '{kind: 1, fw: 0, mw: 4, rwe: 1'b1, pcz: 1'b0, exp_lat: 7};
        tbl[2] = '{kind: 3, fw: 0, mw: 0, rwe: 1'b0, pcz: 1'b0, exp_lat: 3};
        tbl[3] = '{kind: 4, fw: 0, mw: 0, rwe: 1'b0, pcz: 1'b0, exp_lat: 35};
        tbl[4] = '{kind: 2, fw: 2, mw: 1, rwe: 1'b0, pcz: 1'b0, exp_lat: 6};
        tbl[5] = '{kind: 0, fw: 1, mw: 0, rwe: 1'b0, pcz: 1'b1, exp_lat: 3};

        @(negedge clk);
        do_reset(3);
        for (int i = 0; i < 6; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

        // Halted: no strobes and inactive for 20 cycles.
        for (int i = 0; i < 20; i++)
            cyc(1'($urandom), 3'd5, '0, 1'b0, "halt");

        // Restart, then async reset mid-fetch while waitrequest holds it.
        do_reset(1);
        cyc(1'b1, 3'd1, mk(1, 0, 0, 0, 0, 0, 0), 1'b1, "pre_abort_fetch");
        waitrequest = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check(3'd0, '0, 1'b0, "async_reset");
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 3'd0, '0, 1'b0, "restart_reset");
        run_instr(tbl[0], "restart");

        // Random instruction stream against the latency-rule model.
        for (int i = 0; i < 40; i++) begin
            rv.kind = int'($urandom_range(0, 4));
            rv.fw = int'($urandom_range(0, 3));
            rv.mw = int'($urandom_range(0, 3));
            rv.rwe = 1'($urandom);
            rv.pcz = (i == 39);
            rv.exp_lat = lat_of(rv.kind, rv.fw, rv.mw);
            run_instr(rv, $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 3; i++)
            cyc(1'($urandom), 3'd5, '0, 1'b0, "rnd_halt");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
